store_merge: RTL and testbench

STORE_MERGE -- requirements
Module: store_merge

---
 rtl/store_merge_if.sv | 26 ++
 rtl/store_merge.sv | 141 ++++++++++++++
 tb/tb_store_merge.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_merge_if.sv
// Request/response bundle for store_merge: CPU-side store request plus the
// synchronous-RAM read/write port used for read-modify-write of sub-word stores.
interface store_merge_if;
  logic        req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport slave (
    input  req, size, addr, wdata, mem_rdata,
    output busy, done, misalign, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req, size, addr, wdata, mem_rdata,
    input  busy, done, misalign, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_merge.sv
// Store merge unit: word stores write straight through, byte/half stores do a
// read-merge-write of the containing word. `define SUBWORD_STORE_EN enables sub-word stores.
module store_merge (
  input  logic         clk,
  input  logic         rst,
  store_merge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ERR,
`ifdef SUBWORD_STORE_EN
    READ,
    MERGE,
`endif
    WRITE
  } state_t;

  state_t      state;
  logic [31:2] addrLat;
  logic [31:0] wdataLat;
  logic        busyR;
  logic        doneR;
  logic        misalignR;
  logic        memReR;
  logic        memWeR;
  logic        reqIllegal;
  logic        reqWord;
  logic [31:0] writeWord;

`ifdef SUBWORD_STORE_EN
  logic [1:0]  laneLat;
  logic [1:0]  sizeLat;
  logic [31:0] mergeBuf;
  logic [31:0] mergedWord;
`endif

  assign reqWord = (bus.size == 2'b10);

`ifdef SUBWORD_STORE_EN
  assign reqIllegal = (bus.size == 2'b11)
                    | ((bus.size == 2'b01) & bus.addr[0])
                    | (reqWord & (bus.addr[1:0] != 2'b00));

  // Overlay the latched store data onto the word read back from RAM.
  always_comb begin
    // NOTE: default assignment first so every path assigns mergedWord and no latch is inferred.
    mergedWord = mergeBuf;
    case (sizeLat)
      2'b00:   mergedWord[{laneLat, 3'b000} +: 8]     = wdataLat[7:0];
      2'b01:   mergedWord[{laneLat[1], 4'b0000} +: 16] = wdataLat[15:0];
      default: mergedWord = wdataLat;
    endcase
  end

  assign writeWord = mergedWord;
`else
  assign reqIllegal = !reqWord | (bus.addr[1:0] != 2'b00);
  assign writeWord  = wdataLat;
`endif

  assign bus.busy      = busyR;
  assign bus.done      = doneR;
  assign bus.misalign  = misalignR;
  assign bus.mem_re    = memReR;
  assign bus.mem_we    = memWeR;
  assign bus.mem_wdata = memWeR ? writeWord : '0;
  // Address is presented during every memory-facing state, never in IDLE or ERR.
  assign bus.mem_addr  = (busyR && !misalignR) ? {addrLat, 2'b00} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the merge buffer and latched fields are data registers, but they are cleared so a
      // reset leaves no stale store data behind.
      state     <= IDLE;
      addrLat   <= '0;
      wdataLat  <= '0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
      misalignR <= 1'b0;
      memReR    <= 1'b0;
      memWeR    <= 1'b0;
`ifdef SUBWORD_STORE_EN
      laneLat   <= '0;
      sizeLat   <= '0;
      mergeBuf  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      busyR     <= 1'b0;
      doneR     <= 1'b0;
      misalignR <= 1'b0;
      memReR    <= 1'b0;
      memWeR    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            addrLat  <= bus.addr[31:2];
            wdataLat <= bus.wdata;
`ifdef SUBWORD_STORE_EN
            laneLat  <= bus.addr[1:0];
            sizeLat  <= bus.size;
`endif
            busyR    <= 1'b1;
            if (reqIllegal) begin
              state     <= ERR;
              misalignR <= 1'b1;
            end else if (reqWord) begin
              state  <= WRITE;
              memWeR <= 1'b1;
              doneR  <= 1'b1;
            end
`ifdef SUBWORD_STORE_EN
            else begin
              state  <= READ;
              memReR <= 1'b1;
            end
`endif
          end
        end
        ERR:   state <= IDLE;
`ifdef SUBWORD_STORE_EN
        READ: begin
          state <= MERGE;
          busyR <= 1'b1;
        end
        MERGE: begin
          mergeBuf <= bus.mem_rdata;
          state    <= WRITE;
          busyR    <= 1'b1;
          memWeR   <= 1'b1;
          doneR    <= 1'b1;
        end
`endif
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Self-checking bench for store_merge: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level expectation schedule.
module tb_store_merge;

  logic clk;
  logic rst;
  store_merge_if bus ();

  store_merge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- environment RAM ----------------
  logic [31:0] ram [16];
  logic        reSeen;
  logic [3:0]  idxSeen;

  // Synchronous RAM: data for a read strobe is valid for exactly the following cycle.
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      reSeen  = bus.mem_re;
      idxSeen = bus.mem_addr[5:2];
      @(posedge clk);
      #1;
      bus.mem_rdata = reSeen ? ram[idxSeen] : $urandom;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mis;
    logic        re;
    logic        we;
    logic        addrCare;
    logic [31:0] wdata;
    logic [31:0] addr;
  } cyc_t;

  cyc_t        sched [4];
  int          freeCnt = 0;
  bit          started = 0;
  logic [31:0] line;

  function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
`ifdef SUBWORD_STORE_EN
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return (a[0] == 1'b0);
      2'b10:   return (a[1:0] == 2'b00);
      default: return 1'b0;
    endcase
`else
    return (sz == 2'b10) && (a[1:0] == 2'b00);
`endif
  endfunction

  function automatic logic [31:0] mergeExp(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic [31:0] wd);
    int          sh;
    logic [31:0] mask;
    if (sz == 2'b00) begin
      sh   = 8 * lane;
      mask = 32'hFF << sh;
      return (word & ~mask) | ((wd & 32'hFF) << sh);
    end
    sh   = 16 * lane[1];
    mask = 32'hFFFF << sh;
    return (word & ~mask) | ((wd & 32'hFFFF) << sh);
  endfunction

  // sched[0] holds what the outputs must be in the cycle following the current edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) sched[i] = sched[i+1];
    sched[3] = '0;
    if (rst) begin
      for (int i = 0; i < 4; i++) sched[i] = '0;
      freeCnt = 0;
      started = 1;
    end else if (freeCnt > 0) begin
      freeCnt--;
    end else if (bus.req) begin
      line = {bus.addr[31:2], 2'b00};
      if (!legal(bus.size, bus.addr)) begin
        sched[0].busy = 1'b1;
        sched[0].mis  = 1'b1;
        freeCnt = 1;
      end else if (bus.size == 2'b10) begin
        sched[0].busy     = 1'b1;
        sched[0].done     = 1'b1;
        sched[0].we       = 1'b1;
        sched[0].addrCare = 1'b1;
        sched[0].addr     = line;
        sched[0].wdata    = bus.wdata;
        freeCnt = 1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          sched[i].busy     = 1'b1;
          sched[i].addrCare = 1'b1;
          sched[i].addr     = line;
        end
        sched[0].re    = 1'b1;
        sched[2].done  = 1'b1;
        sched[2].we    = 1'b1;
        sched[2].wdata = mergeExp(ram[bus.addr[5:2]], bus.size, bus.addr[1:0], bus.wdata);
        freeCnt = 3;
      end
    end
  end

  // Single compare process: every cycle once the first reset edge has been seen.
  always @(negedge clk) begin
    if (started) begin
      check("busy",      32'(bus.busy),      32'(sched[0].busy));
      check("done",      32'(bus.done),      32'(sched[0].done));
      check("misalign",  32'(bus.misalign),  32'(sched[0].mis));
      check("mem_re",    32'(bus.mem_re),    32'(sched[0].re));
      check("mem_we",    32'(bus.mem_we),    32'(sched[0].we));
      check("mem_wdata", bus.mem_wdata,      sched[0].wdata);
      if (sched[0].addrCare) check("mem_addr", bus.mem_addr, sched[0].addr);
      else if (!sched[0].busy) check("mem_addr_idle", bus.mem_addr, 32'h0);
      check("re_we_excl", 32'(bus.mem_re & bus.mem_we), 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req   = r;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = wd;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"},     32'(bus.busy),     32'h0);
    check({tag, "_done"},     32'(bus.done),     32'h0);
    check({tag, "_misalign"}, 32'(bus.misalign), 32'h0);
    check({tag, "_re"},       32'(bus.mem_re),   32'h0);
    check({tag, "_we"},       32'(bus.mem_we),   32'h0);
    check({tag, "_addr"},     bus.mem_addr,      32'h0);
    check({tag, "_wdata"},    bus.mem_wdata,     32'h0);
  endtask

  logic [31:0] a;

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) ram[i] = $urandom;
    ram[4] = 32'h1122_3344;
    ram[1] = 32'h1122_3344;

    repeat (3) @(negedge clk);
    checkAllZero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("post_reset");

    // Word store.
    drive(1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sw_we",    32'(bus.mem_we), 32'h1);
    check("sw_done",  32'(bus.done),   32'h1);
    check("sw_re",    32'(bus.mem_re), 32'h0);
    check("sw_addr",  bus.mem_addr,    32'h0000_0010);
    check("sw_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_after_busy", 32'(bus.busy), 32'h0);

    // Byte store into lane 2.
    drive(1'b1, 2'b00, 32'h0000_0012, 32'h0000_00A5);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
`ifdef SUBWORD_STORE_EN
    check("sb_re", 32'(bus.mem_re), 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("sb_we",    32'(bus.mem_we), 32'h1);
    check("sb_done",  32'(bus.done),   32'h1);
    check("sb_wdata", bus.mem_wdata,   32'h11A5_3344);
    check("sb_addr",  bus.mem_addr,    32'h0000_0010);
`else
    check("sb_off_mis", 32'(bus.misalign), 32'h1);
    check("sb_off_re",  32'(bus.mem_re),   32'h0);
    check("sb_off_we",  32'(bus.mem_we),   32'h0);
`endif
    @(negedge clk);

    // Half store into upper half.
    drive(1'b1, 2'b01, 32'h0000_0006, 32'h0000_CAFE);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
`ifdef SUBWORD_STORE_EN
    @(negedge clk);
    @(negedge clk);
    check("sh_we",    32'(bus.mem_we), 32'h1);
    check("sh_wdata", bus.mem_wdata,   32'hCAFE_3344);
`else
    check("sh_off_mis", 32'(bus.misalign), 32'h1);
`endif
    @(negedge clk);

    // Misaligned half.
    drive(1'b1, 2'b01, 32'h0000_0005, 32'h0000_1234);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("sh_mis",    32'(bus.misalign), 32'h1);
    check("sh_mis_re", 32'(bus.mem_re),   32'h0);
    check("sh_mis_we", 32'(bus.mem_we),   32'h0);
    @(negedge clk);

    // req held high across an operation with changing fields.
    drive(1'b1, 2'b00, 32'h0000_0012, 32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 2'b10, $urandom & 32'hFFFF_FFFC, $urandom);
    end
`ifdef SUBWORD_STORE_EN
    check("hold_first_wdata", bus.mem_wdata, 32'h11A5_3344);
`endif
    @(negedge clk);
    drive(1'b1, 2'b10, 32'h0000_0020, 32'h1234_5678);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
`ifdef SUBWORD_STORE_EN
    check("hold_next_we",    32'(bus.mem_we), 32'h1);
    check("hold_next_wdata", bus.mem_wdata,   32'h1234_5678);
    check("hold_next_addr",  bus.mem_addr,    32'h0000_0020);
`endif
    repeat (4) @(negedge clk);

    // Reset in the middle of a byte store.
    drive(1'b1, 2'b00, 32'h0000_0012, 32'h0000_00A5);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
`ifdef SUBWORD_STORE_EN
    check("mid_busy", 32'(bus.busy), 32'h1);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkAllZero("rst_mid");
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_we", 32'(bus.mem_we), 32'h0);
    end

`ifndef SUBWORD_STORE_EN
    drive(1'b1, 2'b00, 32'h0000_0000, 32'h0000_0077);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("off_sb0_mis", 32'(bus.misalign), 32'h1);
    check("off_sb0_re",  32'(bus.mem_re),   32'h0);
    check("off_sb0_we",  32'(bus.mem_we),   32'h0);
    @(negedge clk);
    drive(1'b1, 2'b10, 32'h0000_0004, 32'h0BAD_F00D);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check("off_sw_we",    32'(bus.mem_we), 32'h1);
    check("off_sw_wdata", bus.mem_wdata,   32'h0BAD_F00D);
    @(negedge clk);
`endif

    // Randomized traffic with occasional resets.
    repeat (4000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), a, $urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
